// File: rtl/heap_feed_if.sv
// heap_feed_if: stream-in, heap control/data and result-out bundle
// for heap_feed_ctrl; slave is the controller view, master the environment.
interface heap_feed_if #(
  parameter int DATA_WIDTH  = 292,
  parameter int KEY_WIDTH   = 7,
  parameter int SCORE_WIDTH = 16
);
  logic                            start;
  logic                            busy;
  logic                            done;
  logic                            s_valid;
  logic                            s_ready;
  logic [SCORE_WIDTH-1:0]          s_score;
  logic [DATA_WIDTH-KEY_WIDTH-1:0] s_payload;
  logic                            s_last;
  logic [DATA_WIDTH-1:0]           h_din;
  logic                            h_en;
  logic                            h_init;
  logic                            h_in_end;
  logic                            h_flush;
  logic                            h_sort_end;
  logic [DATA_WIDTH-1:0]           h_dout;
  logic                            m_valid;
  logic [DATA_WIDTH-1:0]           m_data;
  logic [15:0]                     in_count;
  logic [15:0]                     out_count;
  logic                            err;

  modport slave (
    input  start, s_valid, s_score, s_payload, s_last,
    input  h_sort_end, h_dout,
    output busy, done, s_ready, h_din, h_en, h_init,
    output h_in_end, h_flush, m_valid, m_data,
    output in_count, out_count, err
  );

  modport master (
    output start, s_valid, s_score, s_payload, s_last,
    output h_sort_end, h_dout,
    input  busy, done, s_ready, h_din, h_en, h_init,
    input  h_in_end, h_flush, m_valid, m_data,
    input  in_count, out_count, err
  );
endinterface

// File: rtl/heap_feed_ctrl.sv
// heap_feed_ctrl: feeds a top-K heap sorter and collects its flush output.
// Optional sort_end watchdog enabled by defining HEAP_FEED_TIMEOUT_EN.
module heap_feed_ctrl #(
  parameter int DATA_WIDTH  = 292,
  parameter int KEY_WIDTH   = 7,
  parameter int NLEVELS     = 6,
  parameter int SCORE_WIDTH = 16,
  parameter int SCORE_SHIFT = 9,
  parameter int FLUSH_LEN   = 62,
  parameter int TIMEOUT     = 255
) (
  input logic        clk,
  input logic        rst,
  heap_feed_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_ENDP,
    S_WAIT, S_FLUSH, S_DRAIN
  } state_t;

  localparam int FW = NLEVELS;
  localparam logic [FW-1:0] F_LAST =
    FW'(FLUSH_LEN - 1);
  localparam logic [SCORE_WIDTH-1:0] K_MAX =
    SCORE_WIDTH'((1 << KEY_WIDTH) - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_endp;
  logic [FW-1:0]          r_fcnt;
  logic                   r_h_en;
  logic [DATA_WIDTH-1:0]  r_h_din;
  logic                   r_m_valid;
  logic [DATA_WIDTH-1:0]  r_m_data;
  logic [15:0]            r_in_cnt;
  logic [15:0]            r_out_cnt;
  logic                   r_err;
  logic                   w_acc;
  logic                   w_hit;
  logic                   w_tmo;
  logic                   w_cap;
  logic                   w_clr;
  logic [SCORE_WIDTH-1:0] w_k;
  logic [KEY_WIDTH-1:0]   w_key;

  assign w_acc = (r_state == S_FILL) && bus.s_valid;
  assign w_hit = |bus.h_dout[KEY_WIDTH-1:0];
  assign w_cap = (r_state == S_FLUSH) && w_hit;
  assign w_clr = (r_state == S_IDLE) && bus.start;
  assign w_k   = bus.s_score >> SCORE_SHIFT;

  // key 0 marks an empty heap slot, so real scores never map to it
  always_comb begin
    w_key = w_k[KEY_WIDTH-1:0];
    if (w_k >= K_MAX)
      w_key = '1;
    else if (w_k == '0)
      w_key = KEY_WIDTH'(1);
  end

`ifdef HEAP_FEED_TIMEOUT_EN
  logic [7:0] r_wd;

  assign w_tmo = (r_state == S_WAIT) &&
                 !bus.h_sort_end &&
                 (r_wd == 8'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wd <= '0;
    else if (r_state != S_WAIT)
      r_wd <= '0;
    else
      r_wd <= r_wd + 8'd1;
  end
`else
  logic w_unused;

  assign w_tmo    = 1'b0;
  assign w_unused = ^32'(TIMEOUT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_INIT;
      S_INIT:  w_next = S_FILL;
      S_FILL:  if (w_acc && bus.s_last) w_next = S_ENDP;
      S_ENDP:  if (r_endp == 2'd2) w_next = S_WAIT;
      S_WAIT:  if (bus.h_sort_end || w_tmo) w_next = S_FLUSH;
      S_FLUSH: if (r_fcnt == F_LAST) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ENDP spans three cycles: last write, one gap, then in_end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_endp    <= '0;
      r_fcnt    <= '0;
      r_h_en    <= 1'b0;
      r_h_din   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_h_en    <= w_acc;
      r_h_din   <= w_acc ? {bus.s_payload, w_key} : '0;
      r_m_valid <= w_cap;
      r_m_data  <= w_cap ? bus.h_dout : '0;
      r_endp    <= (r_state == S_ENDP) ?
                   r_endp + 2'd1 : 2'd0;
      r_fcnt    <= (r_state == S_FLUSH) ?
                   r_fcnt + FW'(1) : '0;
      if (w_clr) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        if (w_acc && (r_in_cnt != 16'hFFFF))
          r_in_cnt <= r_in_cnt + 16'd1;
        if (w_cap)
          r_out_cnt <= r_out_cnt + 16'd1;
        if (w_tmo)
          r_err <= 1'b1;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DRAIN);
  assign bus.s_ready   = (r_state == S_FILL);
  assign bus.h_init    = (r_state == S_INIT);
  assign bus.h_in_end  = (r_state == S_ENDP) &&
                         (r_endp == 2'd2);
  assign bus.h_flush   = (r_state == S_FLUSH);
  assign bus.h_en      = r_h_en;
  assign bus.h_din     = r_h_din;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.in_count  = r_in_cnt;
  assign bus.out_count = r_out_cnt;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_heap_feed_ctrl.sv
// tb_heap_feed_ctrl: table-driven stimulus with h_din / m_data
// scoreboards for heap_feed_ctrl.
module tb_heap_feed_ctrl;
  localparam int DW = 292;
  localparam int KW = 7;
  localparam int SW = 16;
  localparam int PW = DW - KW;
  localparam int FL = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  heap_feed_if #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .SCORE_WIDTH(SW)
  ) bus ();

  heap_feed_ctrl #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .SCORE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] word;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [SW-1:0] sc;
    logic [KW-1:0] k;
    logic          last;
  } vec_t;

  exp_t q_din[$];
  exp_t q_out[$];
  exp_t e_din;
  exp_t e_out;
  vec_t tv[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_en_cyc = -1;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pl(input int i);
    return PW'({9{32'h5A5A_0000 + 32'(i)}});
  endfunction

  function automatic logic [DW-1:0] mk_word(input int i);
    logic [KW-1:0] k;
    k = (i == 0)  ? 7'h15 :
        (i == 17) ? 7'h7F :
        (i == 40) ? 7'h01 :
        (i == 61) ? 7'h33 : 7'h00;
    return {PW'({9{32'hF00D_0000 + 32'(i)}}), k};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.h_en) begin
        if (q_din.size() == 0) begin
          chk("h_en_unexpected", 1, 0);
        end else begin
          e_din = q_din.pop_front();
          chkw("h_din", bus.h_din, e_din.word);
          chk("h_en_cycle", cyc, e_din.cyc);
        end
        last_en_cyc = cyc;
      end
      if (bus.m_valid) begin
        if (q_out.size() == 0) begin
          chk("m_valid_unexpected", 1, 0);
        end else begin
          e_out = q_out.pop_front();
          chkw("m_data", bus.m_data, e_out.word);
          chk("m_valid_cycle", cyc, e_out.cyc);
        end
      end
      if (bus.done) n_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("h_init", bus.h_init, 1);
    tick();
    chk("h_init_pulse", bus.h_init, 0);
    chk("s_ready_fill", bus.s_ready, 1);
  endtask

  task automatic beat(input logic [SW-1:0] sc,
                      input logic [PW-1:0] pl,
                      input logic          last,
                      input logic [KW-1:0] k);
    exp_t e;
    bus.s_valid   = 1'b1;
    bus.s_score   = sc;
    bus.s_payload = pl;
    bus.s_last    = last;
    chk("s_ready", bus.s_ready, 1);
    e.word = {pl, k};
    e.cyc  = cyc + 1;
    q_din.push_back(e);
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_in_end();
    int g = 0;
    while (!bus.h_in_end && g < 20) begin
      tick();
      g++;
    end
    chk("in_end_seen", bus.h_in_end, 1);
    chk("in_end_gap", cyc, last_en_cyc + 2);
  endtask

  task automatic flush_phase(input int exp_start,
                             input bit poke);
    int   g = 0;
    int   nfl = 0;
    exp_t e;
    while (!bus.h_flush && g < 400) begin
      tick();
      g++;
    end
    chk("flush_start_cycle", cyc, exp_start);
    while (bus.h_flush && nfl < 100) begin
      bus.h_dout = mk_word(nfl);
      if (bus.h_dout[KW-1:0] != '0) begin
        e.word = bus.h_dout;
        e.cyc  = cyc + 1;
        q_out.push_back(e);
      end
      bus.start = poke && (nfl == 30);
      nfl++;
      tick();
    end
    bus.h_dout = '0;
    bus.start  = 1'b0;
    chk("flush_len", nfl, FL);
    chk("done_after_flush", bus.done, 1);
    chk("out_count", bus.out_count, 4);
  endtask

  initial begin
    int sc_cyc;
    int we;
    int nd;
    bus.start      = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_score    = '0;
    bus.s_payload  = '0;
    bus.s_last     = 1'b0;
    bus.h_sort_end = 1'b0;
    bus.h_dout     = '0;
    tv[0] = '{16'h0000, 7'd1,   1'b0};
    tv[1] = '{16'h0200, 7'd1,   1'b0};
    tv[2] = '{16'h7E00, 7'd63,  1'b0};
    tv[3] = '{16'hFFFF, 7'd127, 1'b0};
    tv[4] = '{16'h0400, 7'd2,   1'b1};

    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_h_en", bus.h_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_in_count", bus.in_count, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    tick();

    // frame aborted by reset after three beats
    do_start();
    for (int i = 0; i < 3; i++)
      beat(tv[i].sc, mk_pl(10 + i), 1'b0, tv[i].k);
    chk("abort_in_count_pre", bus.in_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_h_en", bus.h_en, 0);
    chk("abort_s_ready", bus.s_ready, 0);
    chk("abort_in_count", bus.in_count, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_done", n_done, 0);

    // main frame from the vector table
    do_start();
    for (int i = 0; i < 5; i++)
      beat(tv[i].sc, mk_pl(i), tv[i].last, tv[i].k);
    wait_in_end();
    chk("in_count_5", bus.in_count, 5);
    repeat (10) tick();
    bus.h_sort_end = 1'b1;
    sc_cyc = cyc;
    tick();
    bus.h_sort_end = 1'b0;
    nd = n_done;
    flush_phase(sc_cyc + 1, 1'b0);
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("done_once", n_done, nd + 1);
    chk("hold_in_count", bus.in_count, 5);
    chk("hold_out_count", bus.out_count, 4);
    chk("err_default", bus.err, 0);

    // gapped input, start poked mid-flush
    do_start();
    beat(16'h0600, mk_pl(20), 1'b0, 7'd3);
    tick();
    beat(16'h1000, mk_pl(21), 1'b0, 7'd8);
    beat(16'hC000, mk_pl(22), 1'b1, 7'd96);
    wait_in_end();
    chk("in_count_3", bus.in_count, 3);
    repeat (3) tick();
    bus.h_sort_end = 1'b1;
    sc_cyc = cyc;
    tick();
    bus.h_sort_end = 1'b0;
    flush_phase(sc_cyc + 1, 1'b1);
    tick();
    chk("poke_idle", bus.busy, 0);
    chk("poke_in_count", bus.in_count, 3);

`ifdef HEAP_FEED_TIMEOUT_EN
    // sort_end never arrives: watchdog forces the flush
    do_start();
    beat(16'h0200, mk_pl(30), 1'b1, 7'd1);
    wait_in_end();
    we = cyc + 1;
    flush_phase(we + 256, 1'b0);
    chk("tmo_err", bus.err, 1);
    tick();
    chk("tmo_err_hold", bus.err, 1);
    do_start();
    chk("tmo_err_clear", bus.err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`else
    we = 0;
    chk("err_tied", bus.err, we[0]);
`endif

    tick();
    chk("din_queue_empty", q_din.size(), 0);
    chk("out_queue_empty", q_out.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/heap_feed_ctrl.md
Name: heap_feed_ctrl

Overview:
- Upstream sequencer and downstream collector for the top-K heap sorter (heap_rtl).
- Accepts a scored keypoint stream, quantises each score into the KEY_WIDTH key field, and packs it with its payload into heap words.
- Drives the heap's init / en / in_end / flush controls, waits for sort_end, then captures the flushed words into a valid-only result stream.
- One instance per heap, between the keypoint scorer and the descriptor stage.

Parameters:
- DATA_WIDTH, 292, heap word width; key occupies bits [KEY_WIDTH-1:0], payload occupies the remaining upper bits.
- KEY_WIDTH, 7, heap key width.
- NLEVELS, 6, heap depth; must match the heap instance.
- SCORE_WIDTH, 16, input score width.
- SCORE_SHIFT, 9, right shift applied to the score before key saturation.
- FLUSH_LEN, 62, number of flush cycles; equals 2^NLEVELS-2.
- TIMEOUT, 255, sort_end watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request; ignored unless the FSM is in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_score  in  SCORE_WIDTH  keypoint score.
- s_payload  in  DATA_WIDTH-KEY_WIDTH  keypoint coordinates and descriptor.
- s_last  in  1  last beat of the frame.
- h_din  out  DATA_WIDTH  heap write word.
- h_en  out  1  heap write enable.
- h_init  out  1  heap init pulse.
- h_in_end  out  1  heap input-end pulse.
- h_flush  out  1  heap flush.
- h_sort_end  in  1  heap sort complete.
- h_dout  in  DATA_WIDTH  heap flush output (combinational on the heap side).
- m_valid  out  1  result word valid.
- m_data  out  DATA_WIDTH  result word.
- in_count  out  16  beats accepted this frame.
- out_count  out  16  words emitted this frame.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; counters cleared. Reset asserted mid-frame aborts the frame immediately; no done pulse is issued.
- FSM states: IDLE, INIT, FILL, ENDP, WAIT, FLUSH, DRAIN.
- IDLE: start=1 moves to INIT, clears in_count, out_count and err.
- INIT: h_init=1 for exactly one cycle, then FILL.
- FILL:
  - s_ready=1.
  - A beat is accepted when s_valid&s_ready.
  - Accepted beat at cycle t → h_din={s_payload,key} and h_en=1 at t+1; otherwise h_en=0 and h_din=0.
  - in_count saturates at 0xFFFF.
  - Accepting a beat with s_last=1 moves to ENDP; s_ready drops on the following cycle.
- Key computation: k = s_score >> SCORE_SHIFT. key = all-ones if k ≥ 2^KEY_WIDTH-1, else k[KEY_WIDTH-1:0].
  - key 0 is reserved as the empty-slot marker, so k=0 is forced to key 1.
- ENDP: one idle cycle with h_en=0, then h_in_end=1 for one cycle, then WAIT.
  - Result: last accept at t → h_en at t+1 → h_in_end at t+3.
- WAIT: hold all heap controls low until h_sort_end=1, then FLUSH on the next cycle.
- FLUSH:
  - h_flush=1 for exactly FLUSH_LEN consecutive cycles, tracked by a 0-based flush counter.
  - Flush cycle t: if h_dout[KEY_WIDTH-1:0]≠0, then m_data=h_dout and m_valid=1 at t+1, and out_count increments; otherwise m_valid=0 at t+1.
  - The stream has no backpressure.
  - After the last flush cycle go to DRAIN.
- DRAIN: one cycle so the final capture registers out; done=1 in this cycle; then IDLE.
- Simultaneous events:
  - start outside IDLE is ignored.
  - s_valid outside FILL is not accepted (s_ready=0).
  - h_sort_end outside WAIT is ignored.
- Empty frame (first accepted beat has s_last=1): one heap write, then normal sequence.
- in_count and out_count hold their values after done until the next start.

Optional Feature:
- Macro HEAP_FEED_TIMEOUT_EN.
- With the macro: an 8-bit watchdog counts cycles spent in WAIT. When it reaches TIMEOUT without h_sort_end, err is set (sticky until the next start) and the FSM goes to FLUSH anyway.
- Without the macro: WAIT waits indefinitely, err is tied 0, and TIMEOUT is unused.

Test Plan:
- Reset mid-FILL after 3 accepted beats → busy=0, h_en=0, s_ready=0, in_count=0 the cycle after rst is asserted; no done pulse.
- start, then 5 beats with scores 0x0000, 0x0200, 0x7E00, 0xFFFF, 0x0400 (last on the fifth) → h_init pulse one cycle after start; h_din keys 1, 1, 63, 127, 2 on consecutive h_en cycles; h_in_end exactly 2 cycles after the last h_en; in_count=5.
- s_valid toggling 1,0,1,1 in FILL → h_en follows the accepted beats one cycle later, with gaps preserved.
- Model heap returns sort_end 10 cycles after in_end, then h_dout keys 0 except 4 nonzero words during 62 flush cycles → h_flush high exactly 62 cycles, 4 m_valid pulses each 1 cycle after the source cycle, out_count=4, done one cycle after the last flush cycle.
- With HEAP_FEED_TIMEOUT_EN and sort_end never asserted → err=1 and h_flush rises 256 cycles after entering WAIT; err clears on the next start.
- start pulsed during FLUSH → ignored, with flush length and counts unchanged.
